y86_decode_regfile: RTL and testbench
=====================================

Name: y86_decode_regfile

Overview:
Parametrised decode and register-file stage for the Y86-64 SEQ/PIPE cores. It is the successor to the flat decode block.
- Selects srcA/srcB from icode/rA/rB.
- Reads a NREG-entry register file and registers val_A/val_B with a valid/stall handshake.
- Accepts a dual-port writeback (E and M) with configurable same-cycle bypass.
- Exposes a debug read port for benches.

Parameters:
DATA_W, 64, register width in bits
NREG, 15, number of architectural registers (indices 0..NREG-1; index 4'hF = RNONE)
BYPASS, 1, 1 = same-cycle writeback forwarded into decode read; 0 = read returns pre-write value
RSP_INIT, 64'h0, reset value of register 4 (%rsp); all others reset to 0

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode request valid
stall  in  1  hold registered outputs; request not accepted
icode  in  4  instruction code
rA  in  4  register specifier A
rB  in  4  register specifier B
wb_en  in  1  writeback enable
dstE  in  4  E-port destination (4'hF = none)
valE  in  DATA_W  E-port data
dstM  in  4  M-port destination (4'hF = none)
valM  in  DATA_W  M-port data
out_valid  out  1  val_A/val_B/srcA/srcB valid
srcA  out  4  selected source A (registered)
srcB  out  4  selected source B (registered)
val_A  out  DATA_W  value of srcA (registered)
val_B  out  DATA_W  value of srcB (registered)
dbg_addr  in  4  debug read address
dbg_data  out  DATA_W  combinational read of dbg_addr (post-write state; 0 for RNONE/out-of-range)

Behaviour:
- Reset (async, rst_n=0):
  - all registers 0 except reg 4 = RSP_INIT
  - out_valid=0; srcA=srcB=4'hF; val_A=val_B=0
  - reset mid-operation discards any in-flight request and any same-edge writeback.
- srcA selection:
  - rA for icode 2 (cmovxx), 4 (rmmovq), 6 (opq), A (pushq)
  - 4 (%rsp) for 9 (ret), B (popq)
  - else 4'hF.
- srcB selection:
  - rB for 4, 5 (mrmovq), 6
  - 4 for 8 (call), 9, A, B
  - else 4'hF.
- Reading 4'hF or any index >= NREG yields 0.
- Latency: 1 cycle. On a rising edge with in_valid=1 and stall=0, the outputs update and out_valid=1 next cycle.
- in_valid=0 and stall=0: out_valid<=0; data outputs hold.
- stall=1: all outputs hold regardless of in_valid or writeback. Writeback still commits.
- Writeback commits at the rising edge when wb_en=1:
  - dstE/dstM = 4'hF or index >= NREG: that port is ignored.
  - dstE == dstM (valid index): valM wins.
- Bypass:
  - BYPASS=1: an accepted read in the same cycle as a write to its source captures the written value, with M priority as above.
  - BYPASS=0: the read captures the old value.
- dbg_data always reflects committed state; it does not bypass.

Decomposition:
- Package y86_pkg holds:
  - icode localparams: I_HALT=0, I_NOP=1, I_CMOV=2, I_IRMOV=3, I_RMMOV=4, I_MRMOV=5, I_OPQ=6, I_JXX=7, I_CALL=8, I_RET=9, I_PUSH=A, I_POP=B
  - R_RSP=4, R_NONE=4'hF.
- Sub-module y86_regfile_core holds the storage array plus the async reset.
  - Ports: 2 write ports (M-priority), 3 combinational read ports (A, B, dbg).
  - Internal BYPASS mux.
- The top contains src selection and the output register/handshake.

Test Plan:
- Reset with RSP_INIT=64'h100 -> dbg_addr=4 gives 64'h100; dbg_addr=0 gives 0; out_valid=0, srcA=srcB=F.
- Write reg5=7 and reg1=9 via E/M ports. Then icode=6, rA=5, rB=1, in_valid=1 -> next cycle out_valid=1, srcA=5, srcB=1, val_A=7, val_B=9.
- Cases at the same edge:
  - wb_en with dstE=dstM=3, valE=11, valM=22 -> dbg reg3=22.
  - icode=2, rA=3 in the same cycle with BYPASS=1 -> val_A=22.
  - Repeated with BYPASS=0 -> val_A=old reg3 value.
- icode=B (popq) then icode=8 (call), with reg4=64'h100:
  - popq: srcA=4, srcB=4, val_A=val_B=64'h100.
  - call: srcA=F, val_A=0, srcB=4.
- stall=1 for 3 cycles while changing icode/rA and writing reg5=99 -> outputs frozen. After stall drops, a request on rA=5 reads 99.
- Assert rst_n=0 asynchronously mid-cycle while out_valid=1 -> out_valid=0 immediately and registers revert to reset values.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 instruction codes, register indices and the decode
// source-selection helpers.
`default_nettype none

package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;

  function automatic logic [3:0] sel_src_a(input logic [3:0] icode, input logic [3:0] ra);
    logic [3:0] src;
    src = R_NONE;
    case (icode)
      I_CMOV, I_RMMOV, I_OPQ, I_PUSH: src = ra;
      I_RET, I_POP:                   src = R_RSP;
      default:                        src = R_NONE;
    endcase
    return src;
  endfunction

  function automatic logic [3:0] sel_src_b(input logic [3:0] icode, input logic [3:0] rb);
    logic [3:0] src;
    src = R_NONE;
    case (icode)
      I_RMMOV, I_MRMOV, I_OPQ:        src = rb;
      I_CALL, I_RET, I_PUSH, I_POP:   src = R_RSP;
      default:                        src = R_NONE;
    endcase
    return src;
  endfunction

endpackage

`default_nettype wire

// File: rtl/y86_regfile_core.sv
// y86_regfile_core: NREG-entry register file with E/M write ports (M wins),
// two decode read ports with optional same-cycle forwarding and a debug read port.
`default_nettype none

module y86_regfile_core
  import y86_pkg::*;
#(
  parameter int               DATA_W   = 64,
  parameter int               NREG     = 15,
  parameter bit               BYPASS   = 1'b1,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [3:0]        dst_e_i,
  input  logic [DATA_W-1:0] val_e_i,
  input  logic [3:0]        dst_m_i,
  input  logic [DATA_W-1:0] val_m_i,
  input  logic [3:0]        rd_a_addr_i,
  output logic [DATA_W-1:0] rd_a_data_o,
  input  logic [3:0]        rd_b_addr_i,
  output logic [DATA_W-1:0] rd_b_data_o,
  input  logic [3:0]        dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  function automatic logic in_range(input logic [3:0] a);
    return (a != R_NONE) && (32'(a) < NREG);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= (4'(i) == R_RSP) ? RSP_INIT : '0;
    end else if (we_i) begin
      // M is tested first so it wins when both ports target the same register
      for (int i = 0; i < NREG; i++) begin
        if (dst_m_i == 4'(i) && dst_m_i != R_NONE)
          regs_q[i] <= val_m_i;
        else if (dst_e_i == 4'(i) && dst_e_i != R_NONE)
          regs_q[i] <= val_e_i;
      end
    end
  end

  function automatic logic [DATA_W-1:0] fwd(
    input logic [3:0]        a,
    input logic [DATA_W-1:0] committed,
    input logic              we,
    input logic [3:0]        de,
    input logic [DATA_W-1:0] ve,
    input logic [3:0]        dm,
    input logic [DATA_W-1:0] vm
  );
    logic [DATA_W-1:0] r;
    r = committed;
    if (we && in_range(a)) begin
      if (dm == a)      r = vm;
      else if (de == a) r = ve;
    end
    return r;
  endfunction

  logic [DATA_W-1:0] w_comm_a, w_comm_b;

  always_comb begin
    w_comm_a   = '0;
    w_comm_b   = '0;
    dbg_data_o = '0;
    if (in_range(rd_a_addr_i)) w_comm_a = regs_q[rd_a_addr_i];
    if (in_range(rd_b_addr_i)) w_comm_b = regs_q[rd_b_addr_i];
    if (in_range(dbg_addr_i))  dbg_data_o = regs_q[dbg_addr_i];
  end

  always_comb begin
    rd_a_data_o = w_comm_a;
    rd_b_data_o = w_comm_b;
    if (BYPASS) begin
      rd_a_data_o = fwd(rd_a_addr_i, w_comm_a, we_i, dst_e_i, val_e_i, dst_m_i, val_m_i);
      rd_b_data_o = fwd(rd_b_addr_i, w_comm_b, we_i, dst_e_i, val_e_i, dst_m_i, val_m_i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/y86_decode_regfile.sv
// y86_decode_regfile: decode source selection, register-file read and the
// registered val_A/val_B output stage with valid/stall handshake.
`default_nettype none

module y86_decode_regfile
  import y86_pkg::*;
#(
  parameter int               DATA_W   = 64,
  parameter int               NREG     = 15,
  parameter bit               BYPASS   = 1'b1,
  parameter logic [DATA_W-1:0] RSP_INIT = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              wb_en,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  output logic              out_valid,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [DATA_W-1:0] val_A,
  output logic [DATA_W-1:0] val_B,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [3:0]        w_sel_a, w_sel_b;
  logic [DATA_W-1:0] w_rd_a, w_rd_b;

  assign w_sel_a = sel_src_a(icode, rA);
  assign w_sel_b = sel_src_b(icode, rB);

  y86_regfile_core #(
    .DATA_W  (DATA_W),
    .NREG    (NREG),
    .BYPASS  (BYPASS),
    .RSP_INIT(RSP_INIT)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (wb_en),
    .dst_e_i    (dstE),
    .val_e_i    (valE),
    .dst_m_i    (dstM),
    .val_m_i    (valM),
    .rd_a_addr_i(w_sel_a),
    .rd_a_data_o(w_rd_a),
    .rd_b_addr_i(w_sel_b),
    .rd_b_data_o(w_rd_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  logic              out_valid_q, out_valid_d;
  logic [3:0]        srca_q, srca_d, srcb_q, srcb_d;
  logic [DATA_W-1:0] val_a_q, val_a_d, val_b_q, val_b_d;

  // Stall freezes everything; an idle cycle only drops valid, data holds.
  always_comb begin
    out_valid_d = out_valid_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;
    if (!stall) begin
      out_valid_d = in_valid;
      if (in_valid) begin
        srca_d  = w_sel_a;
        srcb_d  = w_sel_b;
        val_a_d = w_rd_a;
        val_b_d = w_rd_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      srca_q      <= R_NONE;
      srcb_q      <= R_NONE;
      val_a_q     <= '0;
      val_b_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      srca_q      <= srca_d;
      srcb_q      <= srcb_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
    end
  end

  assign out_valid = out_valid_q;
  assign srcA      = srca_q;
  assign srcB      = srcb_q;
  assign val_A     = val_a_q;
  assign val_B     = val_b_q;

endmodule

`default_nettype wire

// File: tb/tb_y86_decode_regfile.sv
// Bench for y86_decode_regfile: a BYPASS=1 and a BYPASS=0 instance share stimulus
// and are compared against an array-based reference model.
`default_nettype none

module tb_y86_decode_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, stall = 1'b0, wb_en = 1'b0;
  logic [3:0]  icode = 4'h1, rA = 4'hF, rB = 4'hF, dstE = 4'hF, dstM = 4'hF, dbg_addr = 4'h0;
  logic [63:0] valE = '0, valM = '0;

  logic        ov1, ov0;
  logic [3:0]  sa1, sb1, sa0, sb0;
  logic [63:0] va1, vb1, va0, vb0, dd1, dd0;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [63:0] m_regs [16];
  logic        m_valid;
  logic [3:0]  m_sa, m_sb;
  logic [63:0] m_va1, m_vb1, m_va0, m_vb0;

  always #5 clk = ~clk;

  y86_decode_regfile #(.DATA_W(64), .NREG(15), .BYPASS(1'b1), .RSP_INIT(64'h100)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .icode(icode), .rA(rA), .rB(rB),
    .wb_en(wb_en), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .out_valid(ov1), .srcA(sa1), .srcB(sb1), .val_A(va1), .val_B(vb1),
    .dbg_addr(dbg_addr), .dbg_data(dd1));

  y86_decode_regfile #(.DATA_W(64), .NREG(15), .BYPASS(1'b0), .RSP_INIT(64'h100)) dut_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .icode(icode), .rA(rA), .rB(rB),
    .wb_en(wb_en), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .out_valid(ov0), .srcA(sa0), .srcB(sb0), .val_A(va0), .val_B(vb0),
    .dbg_addr(dbg_addr), .dbg_data(dd0));

  function automatic logic [3:0] ref_sel_a(input logic [3:0] ic, input logic [3:0] r);
    case (ic)
      4'h2, 4'h4, 4'h6, 4'hA: return r;
      4'h9, 4'hB:             return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] ref_sel_b(input logic [3:0] ic, input logic [3:0] r);
    case (ic)
      4'h4, 4'h5, 4'h6:       return r;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [63:0] ref_rd(input logic [3:0] a);
    return (a < 4'd15) ? m_regs[a] : 64'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = (i == 4) ? 64'h100 : 64'h0;
    m_valid = 1'b0; m_sa = 4'hF; m_sb = 4'hF;
    m_va1 = '0; m_vb1 = '0; m_va0 = '0; m_vb0 = '0;
  endtask

  // Advance one clock edge and mirror it in the model; returns at posedge+1.
  task automatic tick();
    logic [3:0]  sa, sb;
    logic [63:0] olda, oldb;
    @(posedge clk);
    sa = ref_sel_a(icode, rA);
    sb = ref_sel_b(icode, rB);
    olda = ref_rd(sa);
    oldb = ref_rd(sb);
    if (wb_en) begin
      if (dstE < 4'd15) m_regs[dstE] = valE;
      if (dstM < 4'd15) m_regs[dstM] = valM;
    end
    if (!stall) begin
      m_valid = in_valid;
      if (in_valid) begin
        m_sa = sa; m_sb = sb;
        m_va0 = olda; m_vb0 = oldb;
        m_va1 = ref_rd(sa); m_vb1 = ref_rd(sb);
      end
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; stall = 1'b0; wb_en = 1'b0; dstE = 4'hF; dstM = 4'hF;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ov1); end
    checks++; if (sa1 !== 4'hF || sb1 !== 4'hF) begin errors++; $display("FAIL reset_src got %h/%h exp F/F", sa1, sb1); end
    checks++; if (va1 !== 64'h0 || vb1 !== 64'h0) begin errors++; $display("FAIL reset_val got %h/%h exp 0/0", va1, vb1); end
    dbg_addr = 4'h4; #1;
    checks++; if (dd1 !== 64'h100) begin errors++; $display("FAIL reset_rsp got %h exp 100", dd1); end
    dbg_addr = 4'h0; #1;
    checks++; if (dd1 !== 64'h0) begin errors++; $display("FAIL reset_r0 got %h exp 0", dd1); end
    dbg_addr = 4'hF; #1;
    checks++; if (dd1 !== 64'h0) begin errors++; $display("FAIL dbg_rnone got %h exp 0", dd1); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_read();
    idle();
    wb_en = 1'b1; dstE = 4'h5; valE = 64'd7; dstM = 4'h1; valM = 64'd9;
    tick();
    idle();
    icode = 4'h6; rA = 4'h5; rB = 4'h1; in_valid = 1'b1;
    tick();
    checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", ov1); end
    checks++; if (sa1 !== 4'h5 || sb1 !== 4'h1) begin errors++; $display("FAIL basic_src got %h/%h exp 5/1", sa1, sb1); end
    checks++; if (va1 !== 64'd7 || vb1 !== 64'd9) begin errors++; $display("FAIL basic_val got %0d/%0d exp 7/9", va1, vb1); end
    idle();
    tick();
    checks++; if (ov1 !== 1'b0 || va1 !== 64'd7) begin errors++; $display("FAIL idle_hold got v=%0b a=%0d exp v=0 a=7", ov1, va1); end
  endtask

  task automatic test_same_edge();
    idle();
    wb_en = 1'b1; dstE = 4'h3; valE = 64'd55; dstM = 4'hF;
    tick();
    idle();
    wb_en = 1'b1; dstE = 4'h3; valE = 64'd11; dstM = 4'h3; valM = 64'd22;
    icode = 4'h2; rA = 4'h3; in_valid = 1'b1;
    tick();
    idle();
    dbg_addr = 4'h3; #1;
    checks++; if (dd1 !== 64'd22) begin errors++; $display("FAIL m_priority got %0d exp 22", dd1); end
    checks++; if (va1 !== 64'd22) begin errors++; $display("FAIL bypass_on got %0d exp 22", va1); end
    checks++; if (va0 !== 64'd55) begin errors++; $display("FAIL bypass_off got %0d exp 55", va0); end
    checks++; if (sb1 !== 4'hF || vb1 !== 64'h0) begin errors++; $display("FAIL cmov_srcb got %h/%h exp F/0", sb1, vb1); end
  endtask

  task automatic test_pop_call();
    idle();
    icode = 4'hB; rA = 4'h2; rB = 4'h7; in_valid = 1'b1;
    tick();
    checks++; if (sa1 !== 4'h4 || sb1 !== 4'h4) begin errors++; $display("FAIL pop_src got %h/%h exp 4/4", sa1, sb1); end
    checks++; if (va1 !== 64'h100 || vb1 !== 64'h100) begin errors++; $display("FAIL pop_val got %h/%h exp 100/100", va1, vb1); end
    icode = 4'h8;
    tick();
    checks++; if (sa1 !== 4'hF || va1 !== 64'h0) begin errors++; $display("FAIL call_a got %h/%h exp F/0", sa1, va1); end
    checks++; if (sb1 !== 4'h4 || vb1 !== 64'h100) begin errors++; $display("FAIL call_b got %h/%h exp 4/100", sb1, vb1); end
    idle();
  endtask

  task automatic test_stall();
    logic [3:0]  s_sa, s_sb;
    logic [63:0] s_va, s_vb;
    logic        s_v;
    idle();
    icode = 4'h6; rA = 4'h1; rB = 4'h3; in_valid = 1'b1;
    tick();
    s_v = ov1; s_sa = sa1; s_sb = sb1; s_va = va1; s_vb = vb1;
    for (int c = 0; c < 3; c++) begin
      stall = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      icode = 4'h6; rA = 4'(c + 5); rB = 4'h5;
      wb_en = (c == 0); dstE = 4'h5; valE = 64'd99; dstM = 4'hF;
      tick();
      checks++;
      if (ov1 !== s_v || sa1 !== s_sa || sb1 !== s_sb || va1 !== s_va || vb1 !== s_vb)
        begin errors++; $display("FAIL stall_hold%0d got %0b %h %h %h %h exp %0b %h %h %h %h",
                                 c, ov1, sa1, sb1, va1, vb1, s_v, s_sa, s_sb, s_va, s_vb); end
    end
    idle();
    icode = 4'h6; rA = 4'h5; rB = 4'h0; in_valid = 1'b1;
    tick();
    checks++; if (va1 !== 64'd99 || va0 !== 64'd99) begin errors++; $display("FAIL post_stall got %0d/%0d exp 99", va1, va0); end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      stall    = 1'($urandom_range(0, 3) == 0);
      wb_en    = 1'($urandom_range(0, 1));
      icode    = 4'($urandom_range(0, 15));
      rA       = 4'($urandom_range(0, 15));
      rB       = 4'($urandom_range(0, 15));
      dstE     = 4'($urandom_range(0, 15));
      dstM     = ($urandom_range(0, 3) == 0) ? dstE : 4'($urandom_range(0, 15));
      valE     = {$urandom, $urandom};
      valM     = {$urandom, $urandom};
      tick();
      checks++;
      if (ov1 !== m_valid || sa1 !== m_sa || sb1 !== m_sb || va1 !== m_va1 || vb1 !== m_vb1)
        begin errors++; $display("FAIL rand_byp%0d got %0b %h %h %h %h exp %0b %h %h %h %h",
                                 n, ov1, sa1, sb1, va1, vb1, m_valid, m_sa, m_sb, m_va1, m_vb1); end
      checks++;
      if (ov0 !== m_valid || sa0 !== m_sa || sb0 !== m_sb || va0 !== m_va0 || vb0 !== m_vb0)
        begin errors++; $display("FAIL rand_nobyp%0d got %0b %h %h %h %h exp %0b %h %h %h %h",
                                 n, ov0, sa0, sb0, va0, vb0, m_valid, m_sa, m_sb, m_va0, m_vb0); end
      dbg_addr = 4'($urandom_range(0, 15)); #1;
      checks++;
      if (dd1 !== ref_rd(dbg_addr) || dd0 !== ref_rd(dbg_addr))
        begin errors++; $display("FAIL rand_dbg%0d r%0d got %h/%h exp %h", n, dbg_addr, dd1, dd0, ref_rd(dbg_addr)); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    wb_en = 1'b1; dstE = 4'h5; valE = 64'hABCD; dstM = 4'h4; valM = 64'h77;
    icode = 4'h6; rA = 4'h2; rB = 4'h4; in_valid = 1'b1;
    tick();
    checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %0b exp 1", ov1); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (ov1 !== 1'b0 || ov0 !== 1'b0) begin errors++; $display("FAIL async_valid got %0b/%0b exp 0", ov1, ov0); end
    checks++; if (sa1 !== 4'hF || sb1 !== 4'hF || va1 !== 64'h0 || vb1 !== 64'h0)
      begin errors++; $display("FAIL async_out got %h %h %h %h exp F F 0 0", sa1, sb1, va1, vb1); end
    dbg_addr = 4'h5; #1;
    checks++; if (dd1 !== 64'h0) begin errors++; $display("FAIL async_r5 got %h exp 0", dd1); end
    dbg_addr = 4'h4; #1;
    checks++; if (dd1 !== 64'h100) begin errors++; $display("FAIL async_rsp got %h exp 100", dd1); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (ov1 !== 1'b0 || dd1 !== 64'h100) begin errors++; $display("FAIL post_reset got %0b %h exp 0 100", ov1, dd1); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_same_edge();
    test_pop_call();
    test_stall();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
